// File: rtl/stopwatch_ctrl_if.sv
// Purpose: command pulses in, elapsed/lap/alarm status out, for stopwatch_ctrl.
// Latency: wiring only; timing is set by the controller behind the slave modport.
// Backpressure: none, commands are fire-and-forget pulses and status is always valid.
interface stopwatch_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             lap;
    logic             alarm_set;
    logic [CNT_W-1:0] alarm_ms;
    logic [CNT_W-1:0] elapsed_ms;
    logic [CNT_W-1:0] lap_ms;
    logic             lap_valid;
    logic             ms_tick;
    logic             running;
    logic             alarm;
    logic             ovf;

    // Command source / status consumer side
    modport master (
        output start, stop, clear, lap, alarm_set, alarm_ms,
        input  elapsed_ms, lap_ms, lap_valid, ms_tick, running, alarm, ovf
    );

    // Controller side
    modport slave (
        input  start, stop, clear, lap, alarm_set, alarm_ms,
        output elapsed_ms, lap_ms, lap_valid, ms_tick, running, alarm, ovf
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Purpose: stopwatch sequencer: start/stop/clear FSM, 1 ms prescaler, lap capture, alarm compare.
// Latency: commands act on the next edge; first ms_tick exactly CLK_PER_MS cycles after start.
// Backpressure: none; pulses are always accepted (or ignored by state). Optional: STOPWATCH_AUTOSTOP_EN.
module stopwatch_ctrl #(
    parameter int CLK_PER_MS = 100000,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    stopwatch_ctrl_if.slave sw
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int             PW        = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_PER_MS - 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d, elapsed_inc;
    logic [CNT_W-1:0] lap_q;
    logic [CNT_W-1:0] thr_q;
    logic             armed_q;
    logic             alarm_q;
    logic             ovf_q;
    logic             lap_vld_q;
    logic             running_q;

    logic             tick;
    logic             cmd_stop;
    logic             cmd_start;
    logic             cmd_lap;
    logic             alarm_hit;

    // Command decode, tick/alarm detection and next-state for FSM, prescaler and count
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        elapsed_d   = elapsed_q;
        elapsed_inc = elapsed_q + CNT_W'(1);

        // Strict priority: clear > stop > start > lap; only the winner acts
        cmd_stop  = sw.stop && !sw.clear;
        cmd_start = sw.start && !sw.clear && !sw.stop;
        cmd_lap   = sw.lap && !sw.clear && !sw.stop && !sw.start && (state_q != IDLE);

        tick = (state_q == RUN) && (presc_q == PRESC_MAX);

        // A fresh alarm_set in the same cycle takes precedence over a match on the old threshold
        alarm_hit = tick && armed_q && (thr_q != '0) && (elapsed_inc == thr_q) && !sw.alarm_set;

        if (sw.clear) begin
            state_d = IDLE;
        end else if (cmd_stop && (state_q == RUN)) begin
            state_d = PAUSE;
        end else if (cmd_start && (state_q != RUN)) begin
            state_d = RUN;
        end

`ifdef STOPWATCH_AUTOSTOP_EN
        // Reaching the alarm threshold parks the watch in PAUSE with the count frozen there
        if (!sw.clear && alarm_hit) begin
            state_d = PAUSE;
        end
`endif

        // Prescaler only advances in RUN and is held in PAUSE so a resume finishes the partial ms
        if (sw.clear) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (sw.clear) begin
            elapsed_d = '0;
        end else if (tick) begin
            elapsed_d = elapsed_inc;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: prescaler, count, lap capture, wrap and alarm flags
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            elapsed_q <= '0;
            lap_q     <= '0;
            lap_vld_q <= 1'b0;
            thr_q     <= '0;
            armed_q   <= 1'b0;
            alarm_q   <= 1'b0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            elapsed_q <= elapsed_d;
            running_q <= (state_d == RUN);

            // Lap samples the pre-edge count, so a coincident tick is not yet included
            lap_vld_q <= cmd_lap;
            if (cmd_lap) begin
                lap_q <= elapsed_q;
            end

            if (sw.clear) begin
                ovf_q <= 1'b0;
            end else if (tick && (&elapsed_q)) begin
                ovf_q <= 1'b1;
            end

            // Threshold and armed survive clear; only the alarm flag is dropped
            if (sw.alarm_set) begin
                thr_q   <= sw.alarm_ms;
                armed_q <= 1'b1;
                alarm_q <= 1'b0;
            end else if (sw.clear) begin
                alarm_q <= 1'b0;
            end else if (alarm_hit) begin
                alarm_q <= 1'b1;
                armed_q <= 1'b0;
            end
        end
    end

    assign sw.elapsed_ms = elapsed_q;
    assign sw.lap_ms     = lap_q;
    assign sw.lap_valid  = lap_vld_q;
    assign sw.ms_tick    = tick;
    assign sw.running    = running_q;
    assign sw.alarm      = alarm_q;
    assign sw.ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Purpose: directed table plus hand sequences for stopwatch_ctrl at CLK_PER_MS=4, CNT_W=8.
// Latency: inputs driven and outputs sampled on the falling edge, one row per clock.
// Backpressure: not applicable; every cycle is bounded and the run always ends on its own.
module tb_stopwatch_ctrl;

    localparam int CLK_PER_MS = 4;
    localparam int CNT_W      = 8;

`ifdef STOPWATCH_AUTOSTOP_EN
    localparam int RUN_AFTER_ALARM = 0;
    localparam int EL_LATE_ALARM   = 3;
`else
    localparam int RUN_AFTER_ALARM = 1;
    localparam int EL_LATE_ALARM   = 5;
`endif

    logic clk;
    logic reset;

    stopwatch_ctrl_if #(.CNT_W(CNT_W)) sw_if ();

    stopwatch_ctrl #(
        .CLK_PER_MS (CLK_PER_MS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st, sp, cl, lp;
        int el, run, tk, lv, lapv;
    } vec_t;

    vec_t tbl [28];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t mk(int st, int sp, int cl, int lp, int el, int run, int tk, int lv, int lapv);
        vec_t v;
        v.st = st; v.sp = sp; v.cl = cl; v.lp = lp;
        v.el = el; v.run = run; v.tk = tk; v.lv = lv; v.lapv = lapv;
        return v;
    endfunction

    function automatic int el_o();  return int'(sw_if.elapsed_ms); endfunction
    function automatic int run_o(); return int'(sw_if.running);    endfunction
    function automatic int tk_o();  return int'(sw_if.ms_tick);    endfunction
    function automatic int lv_o();  return int'(sw_if.lap_valid);  endfunction
    function automatic int lap_o(); return int'(sw_if.lap_ms);     endfunction
    function automatic int alm_o(); return int'(sw_if.alarm);      endfunction
    function automatic int ovf_o(); return int'(sw_if.ovf);        endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: wait for the falling edge, then drive this cycle's inputs
    task automatic cyc(input int st, input int sp, input int cl, input int lp, input int aset, input int ams);
        @(negedge clk);
        sw_if.start     = st[0];
        sw_if.stop      = sp[0];
        sw_if.clear     = cl[0];
        sw_if.lap       = lp[0];
        sw_if.alarm_set = aset[0];
        sw_if.alarm_ms  = ams[7:0];
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int found;

        // Rows: inputs applied this cycle, outputs expected this cycle (before the edge)
        tbl[0]  = mk(0,0,0,1, 0,0,0,0,0);   // lap in IDLE
        tbl[1]  = mk(1,0,0,0, 0,0,0,0,0);   // start; IDLE lap gave no lap_valid
        tbl[2]  = mk(0,0,0,0, 0,1,0,0,0);
        tbl[3]  = mk(0,0,0,0, 0,1,0,0,0);
        tbl[4]  = mk(0,0,0,0, 0,1,0,0,0);
        tbl[5]  = mk(0,0,0,0, 0,1,1,0,0);   // first tick, 4 cycles after start
        tbl[6]  = mk(0,0,0,0, 1,1,0,0,0);
        tbl[7]  = mk(0,0,0,0, 1,1,0,0,0);
        tbl[8]  = mk(0,0,0,0, 1,1,0,0,0);
        tbl[9]  = mk(0,0,0,0, 1,1,1,0,0);
        tbl[10] = mk(0,0,0,0, 2,1,0,0,0);
        tbl[11] = mk(0,0,0,0, 2,1,0,0,0);
        tbl[12] = mk(0,0,0,0, 2,1,0,0,0);
        tbl[13] = mk(0,0,0,0, 2,1,1,0,0);
        tbl[14] = mk(0,0,0,0, 3,1,0,0,0);
        tbl[15] = mk(0,0,0,0, 3,1,0,0,0);
        tbl[16] = mk(0,0,0,0, 3,1,0,0,0);
        tbl[17] = mk(0,0,0,0, 3,1,1,0,0);
        tbl[18] = mk(0,0,0,0, 4,1,0,0,0);
        tbl[19] = mk(0,0,0,0, 4,1,0,0,0);
        tbl[20] = mk(0,0,0,0, 4,1,0,0,0);
        tbl[21] = mk(0,0,0,0, 4,1,1,0,0);
        tbl[22] = mk(0,0,0,0, 5,1,0,0,0);
        tbl[23] = mk(0,0,0,0, 5,1,0,0,0);
        tbl[24] = mk(0,0,0,0, 5,1,0,0,0);
        tbl[25] = mk(0,0,0,1, 5,1,1,0,0);   // lap on the 5->6 tick
        tbl[26] = mk(0,0,0,0, 6,1,0,1,5);
        tbl[27] = mk(0,0,0,0, 6,1,0,0,5);

        // Reset state
        reset = 1'b1;
        sw_if.start = 1'b0; sw_if.stop = 1'b0; sw_if.clear = 1'b0;
        sw_if.lap = 1'b0; sw_if.alarm_set = 1'b0; sw_if.alarm_ms = '0;
        idle();
        idle();
        chk("rst_elapsed", el_o(), 0);
        chk("rst_running", run_o(), 0);
        chk("rst_tick", tk_o(), 0);
        chk("rst_lap_valid", lv_o(), 0);
        chk("rst_lap_ms", lap_o(), 0);
        chk("rst_alarm", alm_o(), 0);
        chk("rst_ovf", ovf_o(), 0);
        reset = 1'b0;

        // Table: start, tick cadence, IDLE lap, lap coincident with tick
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_elapsed", i), el_o(), tbl[i].el);
            chk($sformatf("tbl%0d_running", i), run_o(), tbl[i].run);
            chk($sformatf("tbl%0d_tick", i), tk_o(), tbl[i].tk);
            chk($sformatf("tbl%0d_lap_valid", i), lv_o(), tbl[i].lv);
            chk($sformatf("tbl%0d_lap_ms", i), lap_o(), tbl[i].lapv);
            sw_if.start = tbl[i].st[0];
            sw_if.stop  = tbl[i].sp[0];
            sw_if.clear = tbl[i].cl[0];
            sw_if.lap   = tbl[i].lp[0];
        end

        // Pause mid-millisecond and resume: prescaler must be held, not cleared
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("pz_clear_elapsed", el_o(), 0);
        chk("pz_clear_running", run_o(), 0);
        idle();
        chk("pz_running", run_o(), 1);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("pz_hold_running", run_o(), 0);
            chk("pz_hold_elapsed", el_o(), 0);
            chk("pz_hold_tick", tk_o(), 0);
        end
        cyc(1, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            idle();
            if (tk_o() == 1) begin
                n = i;
                break;
            end
        end
        chk("pz_resume_tick_delay", n, 2);
        idle();
        chk("pz_resume_elapsed", el_o(), 1);

        // Alarm at 3 ms
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3);
        cyc(1, 0, 0, 0, 0, 0);
        chk("al_armed_no_alarm", alm_o(), 0);
        for (int i = 0; i < 12; i++) idle();
        chk("al_pre_elapsed", el_o(), 2);
        chk("al_pre_tick", tk_o(), 1);
        chk("al_pre_alarm", alm_o(), 0);
        idle();
        chk("al_fire_alarm", alm_o(), 1);
        chk("al_fire_elapsed", el_o(), 3);
        chk("al_fire_running", run_o(), RUN_AFTER_ALARM);
        for (int i = 0; i < 8; i++) idle();
        chk("al_late_alarm", alm_o(), 1);
        chk("al_late_elapsed", el_o(), EL_LATE_ALARM);
        chk("al_late_running", run_o(), RUN_AFTER_ALARM);

        // Wrap at 255 with threshold 0 armed: ovf sets, alarm never fires
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("wr_alarm_cleared", alm_o(), 0);
        found = 0;
        for (int i = 0; i < 1200; i++) begin
            idle();
            if (el_o() == 255 && tk_o() == 1) begin
                found = 1;
                break;
            end
        end
        chk("wr_reached_255", found, 1);
        chk("wr_pre_ovf", ovf_o(), 0);
        idle();
        chk("wr_elapsed", el_o(), 0);
        chk("wr_ovf", ovf_o(), 1);
        chk("wr_alarm_thr0", alm_o(), 0);
        cyc(0, 0, 1, 0, 0, 0);
        idle();
        chk("wr_clr_ovf", ovf_o(), 0);
        chk("wr_clr_elapsed", el_o(), 0);
        chk("wr_clr_running", run_o(), 0);

        // start+stop+clear together in RUN: clear wins, lap_ms retained, state IDLE
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) idle();
        chk("pr_pre_elapsed", el_o(), 1);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("pr_running", run_o(), 0);
        chk("pr_elapsed", el_o(), 0);
        chk("pr_lap_retained", lap_o(), 5);
        idle();
        chk("pr_idle_lap_ignored", lv_o(), 0);

        // Reset mid-RUN
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) idle();
        chk("mr_pre_elapsed", el_o(), 2);
        cyc(0, 0, 0, 1, 0, 0);
        idle();
        chk("mr_lap_valid", lv_o(), 1);
        chk("mr_lap_ms", lap_o(), 2);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("mr_elapsed", el_o(), 0);
        chk("mr_running", run_o(), 0);
        chk("mr_tick", tk_o(), 0);
        chk("mr_lap_valid0", lv_o(), 0);
        chk("mr_lap_ms0", lap_o(), 0);
        chk("mr_alarm", alm_o(), 0);
        chk("mr_ovf", ovf_o(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the millisecond counter datapath: start/stop/clear control, prescaler-generated 1 ms tick, lap capture and an alarm compare.
- Sits between user-facing pulse inputs (debounced buttons or CPU strobes) and display/readout logic.
- Owns its elapsed-ms register, so downstream logic never drives the counter directly.

Parameters:
- CLK_PER_MS, 100000, clock cycles per millisecond; legal range 2 or more.
- CNT_W, 32, width of the elapsed, lap and alarm values.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: run.
- stop  in  1  single-cycle pulse: pause.
- clear  in  1  single-cycle pulse: zero the count and return to idle.
- lap  in  1  single-cycle pulse: capture the current count.
- alarm_set  in  1  pulse: load alarm_ms and arm the alarm.
- alarm_ms  in  CNT_W  alarm threshold in ms; sampled only when alarm_set=1.
- elapsed_ms  out  CNT_W  current elapsed milliseconds.
- lap_ms  out  CNT_W  last captured lap value.
- lap_valid  out  1  one-cycle pulse when lap_ms is updated.
- ms_tick  out  1  one-cycle pulse on each ms increment.
- running  out  1  high in RUN.
- alarm  out  1  sticky alarm flag.
- ovf  out  1  sticky wrap flag.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset state:
  - state=IDLE; prescaler=0.
  - elapsed_ms=0, lap_ms=0, alarm threshold=0, armed=0.
  - All 1-bit outputs = 0.
- FSM states: IDLE, RUN, PAUSE.
- Command priority within one cycle: clear > stop > start > lap.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --stop--> PAUSE.
  - PAUSE --start--> RUN.
  - any state --clear--> IDLE.
  - start while in RUN: ignored.
  - stop while in IDLE or PAUSE: ignored.
- clear (any state):
  - Next cycle: elapsed_ms=0, prescaler=0, alarm=0, ovf=0.
  - lap_ms and the armed threshold are retained.
- Prescaler:
  - Counts 0..CLK_PER_MS-1, in RUN only.
  - On the cycle it equals CLK_PER_MS-1: it wraps to 0, ms_tick=1 (combinational from that condition), and elapsed_ms increments at that clock edge.
  - Held (not cleared) in PAUSE, so a resume completes the partial millisecond.
  - Latency from start pulse to first ms_tick: exactly CLK_PER_MS cycles.
- Wrap:
  - elapsed_ms at all-ones plus a tick wraps to 0.
  - ovf set on the same edge and held until clear or reset.
- running: registered; equals (state==RUN).
- Lap:
  - Accepted in RUN or PAUSE; ignored in IDLE.
  - lap_ms loads the pre-edge elapsed_ms value; lap_valid=1 for the following cycle.
  - Lap coincident with ms_tick captures the value before the increment.
- Alarm:
  - alarm_set loads the threshold from alarm_ms, sets armed=1 and clears alarm, in any state.
  - alarm sets on the edge where elapsed_ms transitions to a value equal to the threshold while armed=1 and threshold≠0; armed clears at the same time (one-shot).
  - Threshold 0 never fires.
  - alarm_set coincident with a matching tick: the new load wins; no alarm that cycle.
- Reset mid-operation overrides everything: state returns to IDLE with all reset values.

Optional Feature:
- Macro: STOPWATCH_AUTOSTOP_EN.
- Defined: the edge that sets alarm also forces the FSM from RUN to PAUSE (running=0 next cycle). elapsed_ms freezes at the threshold value.
- Undefined: alarm is flag-only and counting continues.
- All other behaviour is identical in both builds.

Test Plan (CLK_PER_MS=4, CNT_W=8):
- reset, then start at cycle 0 -> ms_tick at cycles 4, 8, 12; elapsed_ms = 1, 2, 3; running=1 from cycle 1.
- Run 2 cycles into a ms, stop for 10 cycles, start -> next tick exactly 2 cycles after resume; elapsed_ms unchanged during PAUSE.
- lap asserted on the same cycle as the tick taking elapsed 5->6 -> lap_ms=5, lap_valid high for exactly one cycle; a lap in IDLE produces no lap_valid.
- alarm_set with alarm_ms=3, then run -> alarm rises on the edge where elapsed becomes 3 and stays high. With STOPWATCH_AUTOSTOP_EN defined: running drops and elapsed holds at 3.
- Run until elapsed=255, then one more tick -> elapsed_ms=0, ovf=1; clear -> ovf=0, elapsed_ms=0, state IDLE.
- start, stop and clear asserted together in RUN -> clear wins: IDLE, elapsed_ms=0. reset mid-RUN -> all outputs at reset values next cycle.
